gp_wb_arbiter: RTL and testbench

//  Shares the single GP register-file write port between the in-order writeback stage and N_REQ

---
 rtl/gp_wb_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_gp_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_wb_arbiter.sv
// gp_wb_arbiter
//   Shares the single GP register-file write port between the in-order
//   writeback (WB) stage and N_REQ long-latency side units.
//   - The WB stage always owns the port when it writes.
//   - Side requests are granted round-robin into a small in-order FIFO.
//   - The FIFO drains one entry on each cycle that WB is idle.
//   - A later WB write to the same register kills the queued entry, so
//     the stale side value is dropped when it reaches the head.
//   - A probe output tells the hazard unit whether a live queued entry
//     targets a given register.
//
// Ports
//   iw_clk, iw_rst          clock; asynchronous active-high reset
//   iw_wb_we/addr/data      WB stage write request (highest priority)
//   iw_req_valid/addr/data  packed side requests; requester i uses slice i
//   ow_req_ready            one-hot grant; a request is accepted on valid & ready
//   ow_gp_write_*           register-file write port
//   iw_probe_addr           hazard query address
//   ow_probe_hit            a live queued entry targets iw_probe_addr
//   ow_fifo_count           occupied entries, both live and killed
//   ow_fifo_full            FIFO holds FIFO_DEPTH entries
module gp_wb_arbiter #(
  parameter int N_REQ       = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int HBIT_TGT_GP = 4,
  parameter int HBIT_DATA   = 31
) (
  input  logic                                iw_clk,
  input  logic                                iw_rst,
  input  logic                                iw_wb_we,
  input  logic [HBIT_TGT_GP:0]                iw_wb_addr,
  input  logic [HBIT_DATA:0]                  iw_wb_data,
  input  logic [N_REQ-1:0]                    iw_req_valid,
  input  logic [N_REQ*(HBIT_TGT_GP+1)-1:0]    iw_req_addr,
  input  logic [N_REQ*(HBIT_DATA+1)-1:0]      iw_req_data,
  output logic [N_REQ-1:0]                    ow_req_ready,
  output logic                                ow_gp_write_enable,
  output logic [HBIT_TGT_GP:0]                ow_gp_write_addr,
  output logic [HBIT_DATA:0]                  ow_gp_write_data,
  input  logic [HBIT_TGT_GP:0]                iw_probe_addr,
  output logic                                ow_probe_hit,
  output logic [$clog2(FIFO_DEPTH):0]         ow_fifo_count,
  output logic                                ow_fifo_full
);

  localparam int AW    = HBIT_TGT_GP + 1;
  localparam int DW    = HBIT_DATA + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [AW-1:0]         entAddr_q [FIFO_DEPTH];
  logic [DW-1:0]         entData_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [RR_W-1:0]       rr_q, rr_d;

  logic          full;
  logic          empty;
  logic          pop;
  logic          accept;
  logic          grantFound;
  logic [RR_W-1:0] grantIdx;
  logic [AW-1:0] grantAddr;
  logic [DW-1:0] grantData;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // WB owns the port, so the FIFO only drains on WB-idle cycles.
  assign pop   = !iw_wb_we && !empty && !iw_rst;
  // Ready comes only from the registered count; a same-cycle pop does not
  // free a slot, which keeps iw_wb_we out of the ready path.
  assign accept = grantFound && !full && !iw_rst;

  assign ow_fifo_count = count_q;
  assign ow_fifo_full  = full;

  // Round-robin search: first pass covers requesters at or above the
  // pointer, second pass wraps around to those below it.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    grantAddr  = '0;
    grantData  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grantFound && iw_req_valid[i] && (RR_W'(i) >= rr_q)) begin
        grantFound = 1'b1;
        grantIdx   = RR_W'(i);
        grantAddr  = iw_req_addr[i*AW +: AW];
        grantData  = iw_req_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grantFound && iw_req_valid[i] && (RR_W'(i) < rr_q)) begin
        grantFound = 1'b1;
        grantIdx   = RR_W'(i);
        grantAddr  = iw_req_addr[i*AW +: AW];
        grantData  = iw_req_data[i*DW +: DW];
      end
    end
  end

  assign ow_req_ready = accept ? (N_REQ'(1) << grantIdx) : '0;

  // Write-port mux. A killed head still pops but drives enable low.
  always_comb begin
    ow_gp_write_enable = 1'b0;
    ow_gp_write_addr   = '0;
    ow_gp_write_data   = '0;
    if (!iw_rst) begin
      if (iw_wb_we) begin
        ow_gp_write_enable = 1'b1;
        ow_gp_write_addr   = iw_wb_addr;
        ow_gp_write_data   = iw_wb_data;
      end else if (!empty) begin
        ow_gp_write_enable = live_q[head_q];
        ow_gp_write_addr   = entAddr_q[head_q];
        ow_gp_write_data   = entData_q[head_q];
      end
    end
  end

  // Free slots always have live=0 (cleared on pop and reset), so no
  // occupancy mask is needed here.
  always_comb begin
    ow_probe_hit = 1'b0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      if (live_q[j] && (entAddr_q[j] == iw_probe_addr)) ow_probe_hit = 1'b1;
    end
  end

  // Next-state logic: kill, pop, enqueue, count and round-robin pointer.
  always_comb begin
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rr_d    = rr_q;
    if (iw_wb_we) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (entAddr_q[j] == iw_wb_addr) live_d[j] = 1'b0;
      end
    end
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end
    if (accept) begin
      // A same-cycle WB write to the same register is younger than this entry.
      live_d[tail_q] = !(iw_wb_we && (grantAddr == iw_wb_addr));
      tail_d         = tail_q + PTR_W'(1);
      rr_d           = (grantIdx == RR_W'(N_REQ - 1)) ? '0 : grantIdx + RR_W'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers and FIFO storage.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        entAddr_q[j] <= '0;
        entData_q[j] <= '0;
      end
    end else begin
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      if (accept) begin
        entAddr_q[tail_q] <= grantAddr;
        entData_q[tail_q] <= grantData;
      end
    end
  end

`ifndef SYNTHESIS
  logic [N_REQ-1:0]    stallPrev_q;
  logic [N_REQ*AW-1:0] addrPrev_q;
  logic [N_REQ*DW-1:0] dataPrev_q;

  // Remember which requesters were left waiting, to check they hold still.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      stallPrev_q <= '0;
      addrPrev_q  <= '0;
      dataPrev_q  <= '0;
    end else begin
      stallPrev_q <= iw_req_valid & ~ow_req_ready;
      addrPrev_q  <= iw_req_addr;
      dataPrev_q  <= iw_req_data;
    end
  end

  // Requester stability check plus accept/kill trace messages.
  always @(posedge iw_clk) begin
    if (!iw_rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stallPrev_q[i] && iw_req_valid[i]) begin
          assert ((iw_req_addr[i*AW +: AW] == addrPrev_q[i*AW +: AW]) &&
                  (iw_req_data[i*DW +: DW] == dataPrev_q[i*DW +: DW]))
          else $error("gp_wb_arbiter: requester %0d changed addr/data while waiting", i);
        end
      end
      if (accept)
        $display("gp_wb_arbiter: accept req %0d addr %0h data %0h", grantIdx, grantAddr, grantData);
      if (iw_wb_we) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          if (live_q[j] && (entAddr_q[j] == iw_wb_addr))
            $display("gp_wb_arbiter: kill slot %0d addr %0h", j, entAddr_q[j]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gp_wb_arbiter.sv
// tb_gp_wb_arbiter
//   Self-checking bench for gp_wb_arbiter. The driver applies one cycle of
//   stimulus at a time, asks a queue-based reference model what the DUT
//   should show, and pushes that into scoreboard queues. A monitor on the
//   falling edge pops those expectations and compares them with the DUT.
module tb_gp_wb_arbiter;

  localparam int N_REQ       = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int HBIT_TGT_GP = 4;
  localparam int HBIT_DATA   = 31;
  localparam int AW          = HBIT_TGT_GP + 1;
  localparam int DW          = HBIT_DATA + 1;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  logic                iw_clk = 1'b0;
  logic                iw_rst = 1'b1;
  logic                iw_wb_we = 1'b0;
  logic [AW-1:0]       iw_wb_addr = '0;
  logic [DW-1:0]       iw_wb_data = '0;
  logic [N_REQ-1:0]    iw_req_valid = '0;
  logic [N_REQ*AW-1:0] iw_req_addr = '0;
  logic [N_REQ*DW-1:0] iw_req_data = '0;
  logic [N_REQ-1:0]    ow_req_ready;
  logic                ow_gp_write_enable;
  logic [AW-1:0]       ow_gp_write_addr;
  logic [DW-1:0]       ow_gp_write_data;
  logic [AW-1:0]       iw_probe_addr = '0;
  logic                ow_probe_hit;
  logic [CW-1:0]       ow_fifo_count;
  logic                ow_fifo_full;

  gp_wb_arbiter #(
    .N_REQ(N_REQ), .FIFO_DEPTH(FIFO_DEPTH),
    .HBIT_TGT_GP(HBIT_TGT_GP), .HBIT_DATA(HBIT_DATA)
  ) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst),
    .iw_wb_we(iw_wb_we), .iw_wb_addr(iw_wb_addr), .iw_wb_data(iw_wb_data),
    .iw_req_valid(iw_req_valid), .iw_req_addr(iw_req_addr), .iw_req_data(iw_req_data),
    .ow_req_ready(ow_req_ready),
    .ow_gp_write_enable(ow_gp_write_enable), .ow_gp_write_addr(ow_gp_write_addr),
    .ow_gp_write_data(ow_gp_write_data),
    .iw_probe_addr(iw_probe_addr), .ow_probe_hit(ow_probe_hit),
    .ow_fifo_count(ow_fifo_count), .ow_fifo_full(ow_fifo_full)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            live;
  } entry_t;

  typedef struct {
    bit               en;
    bit               idle;
    logic [N_REQ-1:0] ready;
    bit               probe;
    int               count;
    bit               full;
  } cyc_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  entry_t           modelQ[$];
  int               modelRr = 0;
  cyc_t             cycQ[$];
  wr_t              wrQ[$];
  int               testsRun = 0;
  int               testsFailed = 0;
  bit               checking = 1'b0;
  logic [N_REQ-1:0] lastReady = '0;

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, derive the expected DUT view from the
  // model, queue it for the monitor, then advance the model past the edge.
  task automatic applyStimulus(input bit rst, input bit we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [N_REQ-1:0] rv,
                               input logic [N_REQ*AW-1:0] ra, input logic [N_REQ*DW-1:0] rd,
                               input logic [AW-1:0] pa);
    cyc_t   c;
    wr_t    w;
    entry_t e;
    int     g;
    bit     acc;
    @(posedge iw_clk);
    #1;
    iw_rst        = rst;
    iw_wb_we      = we;
    iw_wb_addr    = wa;
    iw_wb_data    = wd;
    iw_req_valid  = rv;
    iw_req_addr   = ra;
    iw_req_data   = rd;
    iw_probe_addr = pa;
    c = '{default: '0};
    if (rst) begin
      c.idle = 1'b1;
      modelQ.delete();
      modelRr   = 0;
      lastReady = '0;
      cycQ.push_back(c);
      return;
    end
    c.count = modelQ.size();
    c.full  = (modelQ.size() == FIFO_DEPTH);
    if (we) begin
      c.en   = 1'b1;
      w.addr = wa;
      w.data = wd;
    end else if (modelQ.size() > 0) begin
      c.en   = modelQ[0].live;
      w.addr = modelQ[0].addr;
      w.data = modelQ[0].data;
    end else begin
      c.idle = 1'b1;
    end
    if (c.en) wrQ.push_back(w);
    foreach (modelQ[k]) if (modelQ[k].live && modelQ[k].addr == pa) c.probe = 1'b1;
    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      if (g < 0 && rv[(modelRr + k) % N_REQ]) g = (modelRr + k) % N_REQ;
    end
    acc = (g >= 0) && !c.full;
    if (acc) c.ready[g] = 1'b1;
    lastReady = c.ready;
    cycQ.push_back(c);
    if (we) foreach (modelQ[k]) if (modelQ[k].addr == wa) modelQ[k].live = 1'b0;
    if (!we && modelQ.size() > 0) void'(modelQ.pop_front());
    if (acc) begin
      e.addr = ra[g*AW +: AW];
      e.data = rd[g*DW +: DW];
      e.live = !(we && e.addr == wa);
      modelQ.push_back(e);
      modelRr = (g + 1) % N_REQ;
    end
  endtask

  task automatic idleCycle(input logic [AW-1:0] pa);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, '0, pa);
  endtask

  // Monitor: every falling edge, pop the per-cycle expectation; whenever
  // the DUT shows a write, pop and compare the next expected write.
  always @(negedge iw_clk) begin : monitor
    cyc_t c;
    wr_t  w;
    if (checking) begin
      if (cycQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL cycle_record: got none expected one at %0t", $time);
      end else begin
        c = cycQ.pop_front();
        checkOutput("write_enable", 64'(ow_gp_write_enable), 64'(c.en));
        checkOutput("req_ready", 64'(ow_req_ready), 64'(c.ready));
        checkOutput("probe_hit", 64'(ow_probe_hit), 64'(c.probe));
        checkOutput("fifo_count", 64'(ow_fifo_count), 64'(c.count));
        checkOutput("fifo_full", 64'(ow_fifo_full), 64'(c.full));
        if (c.idle) begin
          checkOutput("idle_addr", 64'(ow_gp_write_addr), 64'd0);
          checkOutput("idle_data", 64'(ow_gp_write_data), 64'd0);
        end
      end
      if (ow_gp_write_enable === 1'b1) begin
        if (wrQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write",
                   ow_gp_write_addr, ow_gp_write_data);
        end else begin
          w = wrQ.pop_front();
          checkOutput("write_addr", 64'(ow_gp_write_addr), 64'(w.addr));
          checkOutput("write_data", 64'(ow_gp_write_data), 64'(w.data));
        end
      end
    end
  end

  // Safety net so the run always ends even if the driver stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected normal end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [AW-1:0]    ha [N_REQ];
    logic [DW-1:0]    hd [N_REQ];
    logic [N_REQ-1:0] rv;
    bit               pend [N_REQ];
    bit               r;
    checking = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, '0, '0);
    applyStimulus(1'b1, 1'b1, 5'd2, 32'h1, 2'b11, '0, '0, '0);

    // Single side write retires the cycle after acceptance.
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h15}, 5'd3);
    idleCycle(5'd3);
    idleCycle(5'd3);

    // Two streaming requesters alternate grants.
    repeat (8) applyStimulus(1'b0, 1'b0, '0, '0, 2'b11, {5'd6, 5'd4}, {32'h200, 32'h100}, 5'd4);
    repeat (2) idleCycle('0);

    // WB busy for 6 cycles fills the FIFO, then it drains.
    for (int k = 0; k < 6; k++)
      applyStimulus(1'b0, 1'b1, 5'd1, 32'hC0DE0000 + k, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h777}, 5'd7);
    repeat (6) idleCycle(5'd7);

    // Queued write killed by a younger WB write to the same register.
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hAA}, 5'd5);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h2, 2'b00, '0, '0, 5'd5);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hBB, 2'b00, '0, '0, 5'd5);
    idleCycle(5'd5);
    idleCycle(5'd5);

    // Full FIFO: a pop in the same cycle does not let a request in.
    repeat (4) applyStimulus(1'b0, 1'b1, 5'd2, 32'h22, 2'b01, {5'd0, 5'd8}, {32'h0, 32'h88}, 5'd8);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b01, {5'd0, 5'd8}, {32'h0, 32'h88}, 5'd8);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b01, {5'd0, 5'd8}, {32'h0, 32'h88}, 5'd8);
    repeat (6) idleCycle(5'd8);

    // Reset with entries queued discards them.
    repeat (3) applyStimulus(1'b0, 1'b1, 5'd2, 32'h33, 2'b01, {5'd0, 5'd10}, {32'h0, 32'hA0}, 5'd10);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, '0, 5'd10);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, '0, 5'd10);
    repeat (4) idleCycle(5'd10);

    // Random traffic; waiting requesters keep their addr/data.
    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = 1'b0;
      ha[i]   = '0;
      hd[i]   = '0;
    end
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i]) begin
          rv[i] = ($urandom_range(0, 99) < 60);
          ha[i] = AW'($urandom_range(0, 7));
          hd[i] = $urandom;
        end
      end
      applyStimulus(r, ($urandom_range(0, 99) < 40), AW'($urandom_range(0, 7)), $urandom,
                    rv, {ha[1], ha[0]}, {hd[1], hd[0]}, AW'($urandom_range(0, 7)));
      for (int i = 0; i < N_REQ; i++) pend[i] = rv[i] && !lastReady[i] && !r;
    end
    repeat (8) idleCycle('0);

    @(negedge iw_clk);
    #1;
    checking = 1'b0;
    checkOutput("leftover_writes", 64'(wrQ.size()), 64'd0);
    checkOutput("leftover_cycles", 64'(cycQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
